// File: rtl/alu_input_sequencer.sv
// ALU input sequencer: collects operand A, operand B and an op code from
// switch data on successive load-button presses, drives them to an external
// ALU, then latches the ALU result for display.
//
// state   | meaning
// LOAD_A  | wait for press, capture operand A
// LOAD_B  | wait for press, capture operand B
// LOAD_OP | wait for press, capture op code and carry-in
// EXEC    | one cycle for the ALU to settle, latch its result at the close
// SHOW    | hold the latched result, press returns to LOAD_A
module alu_input_sequencer #(
  parameter int n = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [n-1:0] data_i,
  input  logic         flag_i,
  input  logic         load_btn_i,
  input  logic [n-1:0] alu_result_i,
  input  logic         alu_carry_i,
  input  logic         alu_cero_i,
  output logic [n-1:0] alu_a_o,
  output logic [n-1:0] alu_b_o,
  output logic [3:0]   alu_ctrl_o,
  output logic         alu_flag_in_o,
  output logic [n-1:0] result_o,
  output logic         carry_o,
  output logic         cero_o,
  output logic         valid_o,
  output logic [2:0]   state_o
);

  // The op code is taken from data_i[3:0], so narrower operands cannot work.
  if (n < 4) begin : g_n_check
    $error("alu_input_sequencer: parameter n must be at least 4");
  end

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  // Held as plain bits so that the unused codes 5-7 remain representable
  // and are steered back to LOAD_A by the default branch.
  logic [2:0] state;
  logic       btn_prev;
  logic       press;

  // Rising edge of the (already debounced) load button.
  assign press   = load_btn_i & ~btn_prev;
  assign state_o = state;

  // Sequencer FSM with registered ALU operands and latched result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= LOAD_A;
      btn_prev      <= 1'b0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      alu_ctrl_o    <= '0;
      alu_flag_in_o <= 1'b0;
      result_o      <= '0;
      carry_o       <= 1'b0;
      cero_o        <= 1'b0;
      valid_o       <= 1'b0;
    end else begin
      // The edge detector tracks the button in every state, so a press
      // that lands in EXEC is consumed rather than deferred.
      btn_prev <= load_btn_i;
      valid_o  <= 1'b0;
      case (state)
        LOAD_A: begin
          if (press) begin
            alu_a_o <= data_i;
            state   <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            alu_b_o <= data_i;
            state   <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (press) begin
            alu_ctrl_o    <= data_i[3:0];
            alu_flag_in_o <= flag_i;
            state         <= EXEC;
          end
        end
        EXEC: begin
          result_o <= alu_result_i;
          carry_o  <= alu_carry_i;
          cero_o   <= alu_cero_i;
          valid_o  <= 1'b1;
          state    <= SHOW;
        end
        SHOW: begin
          if (press) begin
            state <= LOAD_A;
          end
        end
        default: begin
          state <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer (n = 4). The bench plays the ALU
// itself by driving hand-computed result/carry/zero values.
module tb_alu_input_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       flag;
  logic       load_btn;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_cero;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_ctrl;
  logic       alu_flag_in;
  logic [3:0] result;
  logic       carry;
  logic       cero;
  logic       valid;
  logic [2:0] state;

  int total = 0;
  int fails = 0;

  alu_input_sequencer #(.n(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .flag_i       (flag),
    .load_btn_i   (load_btn),
    .alu_result_i (alu_result),
    .alu_carry_i  (alu_carry),
    .alu_cero_i   (alu_cero),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_ctrl_o   (alu_ctrl),
    .alu_flag_in_o(alu_flag_in),
    .result_o     (result),
    .carry_o      (carry),
    .cero_o       (cero),
    .valid_o      (valid),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press with a trailing idle cycle so the next press is a fresh edge.
  task automatic press(input logic [3:0] d, input logic f);
    data     = d;
    flag     = f;
    load_btn = 1'b1;
    @(negedge clk);
    load_btn = 1'b0;
    @(negedge clk);
  endtask

  // Op-code press: returns one negedge after the accepting edge (in EXEC).
  task automatic op_press(input logic [3:0] d, input logic f);
    data     = d;
    flag     = f;
    load_btn = 1'b1;
    @(negedge clk);
    load_btn = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    data       = 4'd0;
    flag       = 1'b0;
    load_btn   = 1'b0;
    alu_result = 4'd0;
    alu_carry  = 1'b0;
    alu_cero   = 1'b0;
    #1;
    chk("rst_state", {1'b0, state}, 4'd0);
    chk("rst_a", alu_a, 4'd0);
    chk("rst_result", result, 4'd0);
    chk("rst_valid", {3'b0, valid}, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // 5 + 3 with op 0011
    alu_result = 4'd8; alu_carry = 1'b0; alu_cero = 1'b0;
    chk("t1_s0", {1'b0, state}, 4'd0);
    press(4'd5, 1'b0);
    chk("t1_s1", {1'b0, state}, 4'd1);
    press(4'd3, 1'b0);
    chk("t1_s2", {1'b0, state}, 4'd2);
    op_press(4'b0011, 1'b0);
    chk("t1_s3", {1'b0, state}, 4'd3);
    chk("t1_valid_exec", {3'b0, valid}, 4'd0);
    chk("t1_a", alu_a, 4'd5);
    chk("t1_b", alu_b, 4'd3);
    chk("t1_ctrl", alu_ctrl, 4'b0011);
    chk("t1_flag_in", {3'b0, alu_flag_in}, 4'd0);
    chk("t1_result_pre", result, 4'd0);
    @(negedge clk);
    chk("t1_s4", {1'b0, state}, 4'd4);
    chk("t1_valid", {3'b0, valid}, 4'd1);
    chk("t1_result", result, 4'd8);
    chk("t1_carry", {3'b0, carry}, 4'd0);
    chk("t1_cero", {3'b0, cero}, 4'd0);
    @(negedge clk);
    chk("t1_valid_drop", {3'b0, valid}, 4'd0);
    chk("t1_s4_hold", {1'b0, state}, 4'd4);
    alu_result = 4'hF; alu_carry = 1'b1;
    @(negedge clk);
    chk("t1_result_hold", result, 4'd8);
    chk("t1_carry_hold", {3'b0, carry}, 4'd0);
    press(4'd0, 1'b0);
    chk("t1_back", {1'b0, state}, 4'd0);

    // 15 + 1 wraps to zero with carry
    alu_result = 4'd0; alu_carry = 1'b1; alu_cero = 1'b1;
    press(4'd15, 1'b0);
    press(4'd1, 1'b0);
    op_press(4'b0011, 1'b0);
    @(negedge clk);
    chk("t2_result", result, 4'd0);
    chk("t2_carry", {3'b0, carry}, 4'd1);
    chk("t2_cero", {3'b0, cero}, 4'd1);
    chk("t2_valid", {3'b0, valid}, 4'd1);
    press(4'd0, 1'b0);
    chk("t2_back", {1'b0, state}, 4'd0);

    // 3 - 3 with op 0010
    alu_result = 4'd0; alu_carry = 1'b0; alu_cero = 1'b1;
    press(4'd3, 1'b0);
    press(4'd3, 1'b0);
    op_press(4'b0010, 1'b0);
    chk("t3_ctrl", alu_ctrl, 4'b0010);
    @(negedge clk);
    chk("t3_result", result, 4'd0);
    chk("t3_carry", {3'b0, carry}, 4'd0);
    chk("t3_cero", {3'b0, cero}, 4'd1);
    press(4'd9, 1'b0);
    chk("t3_back", {1'b0, state}, 4'd0);
    chk("t3_a_kept", alu_a, 4'd3);

    // Button held for 10 cycles in LOAD_A
    data = 4'd6; load_btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_a", alu_a, 4'd6);
    chk("t4_state", {1'b0, state}, 4'd1);
    chk("t4_b_kept", alu_b, 4'd3);
    load_btn = 1'b0;
    @(negedge clk);

    // Button held through EXEC and SHOW: no further advance
    alu_result = 4'd13; alu_carry = 1'b0; alu_cero = 1'b0;
    press(4'd7, 1'b0);
    chk("t5_s2", {1'b0, state}, 4'd2);
    op_press(4'b0011, 1'b1);
    load_btn = 1'b1;
    chk("t5_flag_in", {3'b0, alu_flag_in}, 4'd1);
    @(negedge clk);
    chk("t5_s4", {1'b0, state}, 4'd4);
    chk("t5_result", result, 4'd13);
    @(negedge clk);
    chk("t5_s4_held", {1'b0, state}, 4'd4);
    load_btn = 1'b0;
    @(negedge clk);
    chk("t5_s4_after", {1'b0, state}, 4'd4);

    // Asynchronous reset in LOAD_OP
    press(4'd0, 1'b0);
    press(4'd9, 1'b0);
    press(4'd2, 1'b0);
    chk("t6_s2", {1'b0, state}, 4'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6_state", {1'b0, state}, 4'd0);
    chk("t6_a", alu_a, 4'd0);
    chk("t6_b", alu_b, 4'd0);
    chk("t6_ctrl", alu_ctrl, 4'd0);
    chk("t6_flag_in", {3'b0, alu_flag_in}, 4'd0);
    chk("t6_result", result, 4'd0);
    chk("t6_flags", {2'b0, carry, cero}, 4'd0);
    chk("t6_valid", {3'b0, valid}, 4'd0);
    @(posedge clk);
    #1;
    chk("t6_valid_edge", {3'b0, valid}, 4'd0);

    // Button already high when reset releases
    data = 4'd4; load_btn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t7_state", {1'b0, state}, 4'd1);
    chk("t7_a", alu_a, 4'd4);
    load_btn = 1'b0;

    // Illegal state code recovers to LOAD_A
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    force dut.state = 3'd6;
    #1;
    chk("t8_forced", {1'b0, state}, 4'd6);
    release dut.state;
    @(negedge clk);
    chk("t8_recover", {1'b0, state}, 4'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_input_sequencer.md
ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 Parameter n, default 4: operand width in bits; the block SHALL require n >= 4.
REQ-002 clk_i  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 data_i  input  n  switch data; captured as operand A, operand B, or op code (bits [3:0]).
REQ-005 flag_i  input  1  carry-in value, captured together with the op code.
REQ-006 load_btn_i  input  1  debounced, synchronous load button (level); only its rising edge SHALL act.
REQ-007 alu_result_i  input  n  result returned by the downstream ALU.
REQ-008 alu_carry_i  input  1  carry returned by the ALU.
REQ-009 alu_cero_i  input  1  zero flag returned by the ALU.
REQ-010 alu_a_o  output  n  registered operand A driven to the ALU.
REQ-011 alu_b_o  output  n  registered operand B driven to the ALU.
REQ-012 alu_ctrl_o  output  4  registered op code driven to the ALU.
REQ-013 alu_flag_in_o  output  1  registered carry-in driven to the ALU.
REQ-014 result_o  output  n  latched ALU result.
REQ-015 carry_o  output  1  latched ALU carry.
REQ-016 cero_o  output  1  latched ALU zero flag.
REQ-017 valid_o  output  1  one-cycle pulse marking a new latched result.
REQ-018 state_o  output  3  current FSM state code, for display.

Function
REQ-019 Press detection: a register SHALL hold the previous load_btn_i. press = load_btn_i & ~previous. A held button SHALL generate exactly one press.
REQ-020 FSM states and codes: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Codes 5-7 SHALL go to LOAD_A on the next clock.
REQ-021 LOAD_A: on press, capture data_i into alu_a_o and go to LOAD_B. With no press, hold state and registers.
REQ-022 LOAD_B: on press, capture data_i into alu_b_o and go to LOAD_OP.
REQ-023 LOAD_OP: on press, capture data_i[3:0] into alu_ctrl_o and flag_i into alu_flag_in_o, then go to EXEC.
REQ-024 EXEC: unconditionally lasts exactly one cycle. At its closing edge, capture alu_result_i, alu_carry_i and alu_cero_i into result_o, carry_o and cero_o. Assert valid_o high for the following single cycle. Go to SHOW.
REQ-025 SHOW: hold all outputs. On press, go to LOAD_A. Operand registers SHALL keep their old values until they are overwritten.
REQ-026 result_o, carry_o and cero_o SHALL change only at the EXEC capture or at reset.
REQ-027 Latency: exactly 1 clock from the press edge that accepts the op code to the result capture. valid_o SHALL be high during the cycle in which state_o=4 is first shown.
REQ-028 Op codes are forwarded unchecked. For an unsupported code, the block SHALL latch whatever the ALU returns.
REQ-029 A press arriving during EXEC SHALL be ignored. The edge detector SHALL still update, so that press cannot act later.
REQ-030 No arithmetic SHALL be performed in this block; widths pass through unchanged.

Reset
REQ-031 While rst_i=1, the block SHALL immediately, without waiting for a clock: set state to LOAD_A; clear alu_a_o, alu_b_o, alu_ctrl_o, alu_flag_in_o, result_o, carry_o, cero_o and valid_o to 0; set the previous-button register to 0.
REQ-032 Reset asserted in any state, including mid-sequence or during EXEC, SHALL abort the operation with no result capture. After release, the first press SHALL load operand A.
REQ-033 If load_btn_i is already high when reset releases, it SHALL count as a press on the first clock.

Verification (n=4)
REQ-034 Bench SHALL apply presses with data 5, 3, then op 0011 with flag 0. Required response: state_o sequence 0,1,2,3,4; alu_a_o=5, alu_b_o=3, alu_ctrl_o=0011; result_o=8, carry_o=0, cero_o=0; valid_o high for exactly 1 cycle.
REQ-035 Bench SHALL apply data 15, 1, then op 0011 with flag 0. Required response: result_o=0, carry_o=1, cero_o=1.
REQ-036 Bench SHALL apply data 3, 3, then op 0010 with flag 0. Required response: result_o=0, cero_o=1. A following press in SHOW SHALL give state_o=0, with alu_a_o still 3.
REQ-037 Bench SHALL hold load_btn_i high for 10 cycles in LOAD_A with data 6. Required response: only alu_a_o=6 captured, state_o=1, no further advance.
REQ-038 Bench SHALL assert rst_i asynchronously, between clock edges, while in LOAD_OP. Required response: all outputs 0 and state_o=0 before the next clock edge; no valid_o pulse.
REQ-039 Bench SHALL force illegal state code 6. Required response: state_o=0 after one clock.
